// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO read/write-side arbiters.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } arb_state_t;

  localparam int ARB_BURST_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester strictly after 'last', wrapping modulo NREQ.
// Purely combinational so both FIFO arbiters can share it.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] winner,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  // Offset 1 first so the previous winner has lowest priority this round.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        found = 1'b1;
        idx   = IDW'((int'(last) + i) % NREQ);
        winner[(int'(last) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares the read port of one async FIFO among NREQ consumers with round-robin
// bursts of up to BURST pops, staging each popped word in a one-entry tagged buffer.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = ARB_BURST_DEFAULT,
  parameter int IDW   = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rdy,
  output logic [NREQ-1:0]  gnt,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [IDW-1:0]   out_id
);

  localparam int CNTW = $clog2(BURST + 1);
  localparam logic [CNTW-1:0] BURST_C = CNTW'(BURST);

  arb_state_t state;
  arb_state_t next_state;

  logic [IDW-1:0]  cur;
  logic [IDW-1:0]  last;
  logic [CNTW-1:0] cnt;
  logic [NREQ-1:0] pick_winner;
  logic [IDW-1:0]  pick_idx;
  logic            pick_found;
  logic            pop;
  logic            accept;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // A pop may overwrite the staged word only when it is leaving in the same cycle.
  assign accept = out_valid && rdy[cur];
  assign pop    = (state == GRANT) && !rempty && req[cur] && (cnt < BURST_C) &&
                  (!out_valid || rdy[cur]);
  assign rinc   = pop && rrst_n;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|req && !rempty && pick_found) begin
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (!pop && ((cnt == BURST_C) || !req[cur] || rempty)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid || rdy[cur]) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      cnt       <= '0;
      cur       <= '0;
      last      <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (next_state == GRANT) begin
            gnt  <= pick_winner;
            cur  <= pick_idx;
            last <= pick_idx;
            cnt  <= '0;
          end
        end
        GRANT: begin
          if (pop) begin
            out_data  <= rdata;
            out_id    <= cur;
            out_valid <= 1'b1;
            cnt       <= cnt + CNTW'(1);
          end else if (accept) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (next_state == IDLE) begin
            out_valid <= 1'b0;
            gnt       <= '0;
          end
        end
        default: begin
          gnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: a queue-backed FIFO model feeds the DUT,
// stimulus pushes expected (id, data) pairs, a forked monitor checks every handshake.
module tb_fifo_rd_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [DSIZE-1:0] data;
  } exp_t;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  rdy;
  logic [NREQ-1:0]  gnt;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic [IDW-1:0]   out_id;

  logic [DSIZE-1:0] mem [0:255];
  logic [7:0]       wr_ptr = 8'd0;
  logic [7:0]       rd_ptr = 8'd0;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  fifo_rd_arbiter #(
    .NREQ  (NREQ),
    .DSIZE (DSIZE),
    .BURST (BURST),
    .IDW   (IDW)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .req       (req),
    .rdy       (rdy),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 rclk = ~rclk;

  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr];

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_word(input logic [IDW-1:0] id, input logic [DSIZE-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic run_monitor();
    exp_t e;
    logic [NREQ-1:0] one;
    one = 4'b0001;
    forever begin
      @(negedge rclk);
      #2;
      if (rrst_n) begin
        if (rempty) check("rinc_while_empty", 32'(rinc), 32'd0);
        if (out_valid) check("gnt_vs_out_id", 32'(gnt), 32'(one << out_id));
        if (out_valid && rdy[out_id]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_id", 32'(out_id), 32'(e.id));
            check("out_data", 32'(out_data), 32'(e.data));
          end
        end
      end
    end
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] want, input string name);
    int n;
    n = 0;
    @(negedge rclk);
    while (gnt == '0 && n < 200) begin
      @(negedge rclk);
      n++;
    end
    check(name, 32'(gnt), 32'(want));
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge rclk);
      n++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gnt != '0) && n < 400) begin
      @(negedge rclk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_gnt"}, 32'(gnt), 32'd0);
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b0;
    req    = 4'b1111;
    rdy    = 4'b0100;
    fork
      run_monitor();
    join_none

    // Reset with requests pending and a non-empty FIFO.
    for (int i = 0; i < 6; i++) begin
      push_word(8'hA0 + 8'(i));
      expect_word(2'd2, 8'hA0 + 8'(i));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge rclk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rinc", 32'(rinc), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
    end
    req    = 4'b0100;
    rrst_n = 1'b1;

    // Single consumer: one burst of 4, then re-grant for the remaining 2.
    wait_gnt(4'b0100, "single_gnt");
    for (int i = 0; i < 4; i++) begin
      check("single_rinc_burst", 32'(rinc), 32'd1);
      @(negedge rclk);
    end
    check("single_rinc_stop", 32'(rinc), 32'd0);
    begin
      int n;
      n = 0;
      while (gnt != '0 && n < 50) begin
        @(negedge rclk);
        n++;
      end
      check("single_release", 32'(gnt), 32'd0);
    end
    wait_gnt(4'b0100, "single_regrant");
    wait_done("single_done");
    req = 4'b0000;

    // Round robin from a fresh reset: 0,1,2,3,0 with 4 words each.
    apply_reset();
    rdy = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      push_word(8'h40 + 8'(i));
      expect_word(IDW'((i / 4) % 4), 8'h40 + 8'(i));
    end
    req = 4'b1111;
    wait_gnt(4'b0001, "rr_first_gnt");
    wait_done("rr_done");
    req = 4'b0000;

    // Backpressure on consumer 1; other consumers' rdy must be ignored.
    rdy = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      push_word(8'hB0 + 8'(i));
      expect_word(2'd1, 8'hB0 + 8'(i));
    end
    req = 4'b0010;
    wait_gnt(4'b0010, "bp_gnt");
    @(negedge rclk);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_rinc", 32'(rinc), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'hB0);
      if (i < 2) @(negedge rclk);
    end
    rdy = 4'b1111;
    wait_done("bp_done");
    req = 4'b0000;

    // FIFO runs dry after 2 pops; grant must release and wait for refill.
    for (int i = 0; i < 2; i++) begin
      push_word(8'hC0 + 8'(i));
      expect_word(2'd3, 8'hC0 + 8'(i));
    end
    req = 4'b1000;
    wait_gnt(4'b1000, "empty_gnt");
    wait_done("empty_drain");
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("empty_no_regrant", 32'(gnt), 32'd0);
    end
    push_word(8'hC2);
    expect_word(2'd3, 8'hC2);
    wait_gnt(4'b1000, "empty_refill_gnt");
    wait_done("empty_refill_done");
    req = 4'b0000;

    // Reset while a word is held: it is dropped and priority restarts at 0.
    rdy = 4'b0000;
    for (int i = 0; i < 8; i++) push_word(8'hD0 + 8'(i));
    req = 4'b0100;
    wait_gnt(4'b0100, "mrst_gnt");
    @(negedge rclk);
    wait_out_valid();
    rrst_n = 1'b0;
    #1;
    check("mrst_rinc", 32'(rinc), 32'd0);
    @(posedge rclk);
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_gnt_clear", 32'(gnt), 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    req    = 4'b1111;
    rdy    = 4'b1111;
    for (int i = 1; i < 5; i++) expect_word(2'd0, 8'hD0 + 8'(i));
    for (int i = 5; i < 8; i++) expect_word(2'd1, 8'hD0 + 8'(i));
    wait_gnt(4'b0001, "mrst_next_gnt");
    wait_done("mrst_done");
    req = 4'b0000;

    repeat (3) @(negedge rclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin arbiter that shares the read port of one async FIFO (read domain, rclk) among NREQ consumers.
- Drives the FIFO read-increment (rinc) from the winning consumer's demand, gated by the FIFO empty flag.
- Registers each popped word into a one-entry output stage tagged with the consumer ID.
- Sits between the FIFO read-pointer/empty logic plus memory read port and the consumer blocks in the rclk domain.

Parameters:
- NREQ, 4, number of consumers sharing the read port (2..16).
- DSIZE, 8, FIFO data width.
- BURST, 4, maximum pops per grant before forced re-arbitration (>=1).
- IDW, 2, width of consumer ID; must equal clog2(NREQ).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset; synchronous, active-low.
- rempty  in  1  FIFO empty flag (synchronised, pessimistic).
- rdata  in  DSIZE  FIFO memory read data at the current read pointer; valid same cycle.
- rinc  out  1  FIFO pop strobe, combinational.
- req  in  NREQ  per-consumer read request, level.
- rdy  in  NREQ  per-consumer accept of the output stage.
- gnt  out  NREQ  one-hot registered grant.
- out_valid  out  1  output stage holds a word.
- out_data  out  DSIZE  popped word.
- out_id  out  IDW  consumer the word belongs to.

Behaviour:
- Reset (rrst_n low at rclk edge): state=IDLE, gnt=0, out_valid=0, out_data=0, out_id=0, burst count=0, last winner=NREQ-1, so consumer 0 has first priority. Reset mid-burst discards the held word, and no rinc is issued that cycle.
- States:
  - IDLE: if |req and !rempty, pick the first requester strictly after the last winner (wrapping modulo NREQ). Load gnt one-hot, cur=winner, last=winner, cnt=0, go to GRANT. Otherwise stay in IDLE.
  - GRANT: pop = !rempty & req[cur] & (cnt<BURST) & (!out_valid | rdy[cur]). rinc=pop.
    - On pop: out_data<=rdata, out_id<=cur, out_valid<=1, cnt<=cnt+1.
    - On accept without pop (out_valid & rdy[cur] & !pop): out_valid<=0.
    - Stop condition: cnt==BURST, or !req[cur], or rempty, evaluated when pop is 0. On stop go to DRAIN.
  - DRAIN: gnt held, rinc=0. When !out_valid, or out_valid & rdy[cur]: clear out_valid, gnt<=0, go to IDLE.
- rinc is never asserted outside GRANT and never while rempty=1 (redundant with the FIFO's own gating; required anyway).
- Throughput: one word per cycle in GRANT when rdy[cur] is held high. Latency from pop to out_valid is 1 cycle.
- rdy of non-granted consumers is ignored. out_id always matches gnt while out_valid=1.
- Requester drops req mid-grant: no further pops; the held word is still delivered before release.
- rempty rising mid-burst: pops stop the same cycle, and the grant is released via DRAIN (no waiting for refill).
- Minimum re-arbitration gap: 1 cycle in IDLE between grants.
- Fairness: with all requesters continuously asserting and the FIFO never empty, each gets BURST words per round, in order last+1, last+2, ...
- cnt width is clog2(BURST+1) and never exceeds BURST.

Decomposition:
- Shared package fifo_pkg: arb_state_t enum (IDLE, GRANT, DRAIN) and constant ARB_BURST_DEFAULT=4.
- One sub-module: rr_pick. Combinational: inputs req and last, output a one-hot winner plus its encoded index. Reusable by the write-side arbiter.

Test Plan:
- Reset: rrst_n=0 for 2 cycles with req=4'b1111 and rempty=0 -> gnt=0, rinc=0, out_valid=0, out_id=0 throughout.
- Single consumer: req=4'b0100, FIFO holds 6 words (A0..A5), rdy[2]=1 -> gnt=4'b0100, rinc high 4 consecutive cycles, out_data A0..A3 with out_id=2, then DRAIN, IDLE, re-grant to 2 for A4..A5.
- Round robin: req=4'b1111, FIFO deep, all rdy=1, BURST=4 -> grants in order 0,1,2,3,0, 4 words each, out_id matching.
- Backpressure: grant to consumer 1 and rdy[1] low for 3 cycles after the first pop -> rinc=0 during the stall, out_data held stable, no word lost or duplicated, pops resume when rdy[1]=1.
- Empty mid-burst: rempty rises after 2 pops -> rinc drops the same cycle, cnt=2, the held word is delivered, gnt clears, and re-arbitration waits for rempty=0.
- Mid-burst reset: assert rrst_n=0 with out_valid=1 -> next cycle out_valid=0, gnt=0, state IDLE, and the next grant goes to consumer 0.
